// File: rtl/if_fetch_stage_if.sv
// if_fetch_stage_if
//   Groups the fetch stage's pipeline-control inputs, instruction ROM port and
//   IF/ID register outputs into one bundle.
//   master : the fetch stage itself (drives ROM address/enable and IF/ID).
//   slave  : the surrounding pipeline and ROM (drive stall/flush/redirect and
//            return the instruction word).
//   Signals:
//     stall, flush, redirect_valid, redirect_target : pipeline control
//     rom_ce, rom_addr, rom_inst                    : instruction ROM port
//     id_pc, id_inst, id_valid                      : IF/ID register contents
//   Optional macro IF_MISALIGN_TRAP_EN adds if_misalign (master output).
interface if_fetch_stage_if;
  logic        stall;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        rom_ce;
  logic [31:0] rom_addr;
  logic [31:0] rom_inst;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic        id_valid;
`ifdef IF_MISALIGN_TRAP_EN
  logic        if_misalign;
`endif

  modport master (
    input  stall, flush, redirect_valid, redirect_target, rom_inst,
    output rom_ce, rom_addr, id_pc, id_inst, id_valid
`ifdef IF_MISALIGN_TRAP_EN
    , output if_misalign
`endif
  );

  modport slave (
    output stall, flush, redirect_valid, redirect_target, rom_inst,
    input  rom_ce, rom_addr, id_pc, id_inst, id_valid
`ifdef IF_MISALIGN_TRAP_EN
    , input if_misalign
`endif
  );
endinterface

// File: rtl/if_fetch_stage.sv
// if_fetch_stage
//   Instruction-fetch stage in front of a combinational instruction ROM.
//   Owns the PC, drives the ROM enable/address and captures the returned word
//   into the IF/ID register. Handles stall, flush and branch/jump redirect, and
//   buffers one redirect that arrives while stalled so it is applied on release.
//   Ports:
//     clk  : system clock, rising edge
//     rst  : asynchronous active-high reset
//     bus  : if_fetch_stage_if.master (control in, ROM port, IF/ID out)
//   Parameters:
//     RESET_PC : PC after reset
//     NOP_INST : word placed in id_inst when IF/ID is squashed or empty
//   Optional macro IF_MISALIGN_TRAP_EN: redirect targets are word-aligned on load
//   and a one-cycle if_misalign pulse flags a target with nonzero low bits.
//
//   state | meaning
//   IDLE  | first edge after reset; ROM enable comes up, no capture
//   RUN   | fetching, one instruction per edge
//   HOLD  | stalled; PC and id_pc frozen, redirects go to the pending buffer
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic clk,
  input  logic rst,
  if_fetch_stage_if.master bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        pend_valid_q, pend_valid_d;
  logic [31:0] pend_target_q, pend_target_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic [31:0] id_inst_q, id_inst_d;
  logic        id_valid_q, id_valid_d;
  logic        rom_ce_q;

  logic        redirect_apply;
  logic [31:0] redirect_pick;
  logic [31:0] redirect_load;

  // A fresh redirect beats a buffered one; both only take effect when not stalled.
  always_comb begin
    redirect_apply = 1'b0;
    redirect_pick  = bus.redirect_target;
    if ((state_q != IDLE) && !bus.stall) begin
      if (bus.redirect_valid) begin
        redirect_apply = 1'b1;
      end else if (pend_valid_q) begin
        redirect_apply = 1'b1;
        redirect_pick  = pend_target_q;
      end
    end
  end

`ifdef IF_MISALIGN_TRAP_EN
  logic misalign_d, misalign_q;
  assign redirect_load = {redirect_pick[31:2], 2'b00};
  assign misalign_d    = redirect_apply && (redirect_pick[1:0] != 2'b00);
  assign bus.if_misalign = misalign_q;
`else
  assign redirect_load = redirect_pick;
`endif

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    pend_valid_d  = pend_valid_q;
    pend_target_d = pend_target_q;
    id_pc_d       = id_pc_q;
    id_inst_d     = id_inst_q;
    id_valid_d    = id_valid_q;
    case (state_q)
      IDLE: begin
        state_d = RUN;
      end
      RUN, HOLD: begin
        state_d = bus.stall ? HOLD : RUN;
        if (redirect_apply) begin
          // Squash the word fetched from the old path: this is the single bubble.
          pc_d         = redirect_load;
          id_pc_d      = pc_q;
          id_inst_d    = NOP_INST;
          id_valid_d   = 1'b0;
          pend_valid_d = 1'b0;
        end else if (!bus.stall) begin
          id_inst_d  = bus.rom_inst;
          id_pc_d    = pc_q;
          id_valid_d = 1'b1;
          pc_d       = pc_q + 32'd4;
        end else if (bus.redirect_valid) begin
          // Last redirect seen during a stall is the one that survives.
          pend_valid_d  = 1'b1;
          pend_target_d = bus.redirect_target;
        end
        if (bus.flush) begin
          id_inst_d  = NOP_INST;
          id_valid_d = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      pc_q          <= RESET_PC;
      pend_valid_q  <= 1'b0;
      pend_target_q <= 32'h0;
      id_pc_q       <= 32'h0;
      id_inst_q     <= NOP_INST;
      id_valid_q    <= 1'b0;
      rom_ce_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      pend_valid_q  <= pend_valid_d;
      pend_target_q <= pend_target_d;
      id_pc_q       <= id_pc_d;
      id_inst_q     <= id_inst_d;
      id_valid_q    <= id_valid_d;
      rom_ce_q      <= 1'b1;
    end
  end

`ifdef IF_MISALIGN_TRAP_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= misalign_d;
    end
  end
`endif

  assign bus.rom_ce   = rom_ce_q;
  assign bus.rom_addr = pc_q;
  assign bus.id_pc    = id_pc_q;
  assign bus.id_inst  = id_inst_q;
  assign bus.id_valid = id_valid_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
module tb_if_fetch_stage;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  if_fetch_stage_if bus();

  logic [31:0] rom [256];
  assign bus.rom_inst = rom[bus.rom_addr[9:2]];

  if_fetch_stage #(.RESET_PC(32'h0), .NOP_INST(NOP)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: architectural view of the fetch stage.
  bit          m_run, m_ce, m_pend_v, m_id_valid, m_mis;
  logic [31:0] m_pc, m_pend_t, m_id_pc, m_id_inst;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_ce = 0; m_pc = 32'h0; m_pend_v = 0; m_pend_t = 32'h0;
    m_id_pc = 32'h0; m_id_inst = NOP; m_id_valid = 0; m_mis = 0;
  endtask

  task automatic model_step(input bit s, input bit f, input bit rv, input logic [31:0] rt);
    logic [31:0] tgt;
    bit redir;
    m_mis = 0;
    if (!m_run) begin
      m_run = 1; m_ce = 1;
      return;
    end
    if (!s) begin
      redir = 1;
      if (rv) tgt = rt;
      else if (m_pend_v) tgt = m_pend_t;
      else redir = 0;
      if (redir) begin
`ifdef IF_MISALIGN_TRAP_EN
        m_mis = (tgt[1:0] != 2'b00);
        tgt = tgt & 32'hFFFF_FFFC;
`endif
        m_id_pc = m_pc; m_id_inst = NOP; m_id_valid = 0;
        m_pc = tgt; m_pend_v = 0;
      end else begin
        m_id_inst = rom[m_pc[9:2]]; m_id_pc = m_pc; m_id_valid = 1;
        m_pc = m_pc + 32'd4;
      end
    end else if (rv) begin
      m_pend_v = 1; m_pend_t = rt;
    end
    if (f) begin
      m_id_inst = NOP; m_id_valid = 0;
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, ".rom_ce"},   {31'b0, bus.rom_ce},   {31'b0, m_ce});
    check({tag, ".rom_addr"}, bus.rom_addr,          m_pc);
    check({tag, ".id_pc"},    bus.id_pc,             m_id_pc);
    check({tag, ".id_inst"},  bus.id_inst,           m_id_inst);
    check({tag, ".id_valid"}, {31'b0, bus.id_valid}, {31'b0, m_id_valid});
`ifdef IF_MISALIGN_TRAP_EN
    check({tag, ".misalign"}, {31'b0, bus.if_misalign}, {31'b0, m_mis});
`endif
  endtask

  task automatic step(input bit s, input bit f, input bit rv, input logic [31:0] rt);
    bus.stall = s; bus.flush = f; bus.redirect_valid = rv; bus.redirect_target = rt;
    model_step(s, f, rv, rt);
    @(posedge clk); #1;
    check_model("step");
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, ".rom_ce"},   {31'b0, bus.rom_ce},   32'h0);
    check({tag, ".rom_addr"}, bus.rom_addr,          32'h0);
    check({tag, ".id_pc"},    bus.id_pc,             32'h0);
    check({tag, ".id_inst"},  bus.id_inst,           NOP);
    check({tag, ".id_valid"}, {31'b0, bus.id_valid}, 32'h0);
  endtask

  // Asynchronous reset pulse placed between clock edges, then released.
  task automatic do_reset();
    bus.stall = 0; bus.flush = 0; bus.redirect_valid = 0; bus.redirect_target = 32'h0;
    #2 rst = 1'b1;
    #1 check_reset_vals("async_rst");
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    #1 check({"pre_idle", ".rom_ce"}, {31'b0, bus.rom_ce}, 32'h0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = $urandom;
    rom[0] = 32'h11; rom[1] = 32'h22; rom[2] = 32'h33; rom[3] = 32'h44;

    rst = 1'b1;
    bus.stall = 0; bus.flush = 0; bus.redirect_valid = 0; bus.redirect_target = 32'h0;
    model_reset();
    @(posedge clk); #1;
    check_reset_vals("reset");
    rst = 1'b0;

    // Reset release and straight-line fetch.
    step(0, 0, 0, 0);
    check("idle_ce", {31'b0, bus.rom_ce}, 32'h1);
    check("idle_valid", {31'b0, bus.id_valid}, 32'h0);
    step(0, 0, 0, 0);
    check("f0_inst", bus.id_inst, 32'h11); check("f0_pc", bus.id_pc, 32'h0);
    step(0, 0, 0, 0);
    check("f1_inst", bus.id_inst, 32'h22); check("f1_pc", bus.id_pc, 32'h4);
    step(0, 0, 0, 0);
    check("f2_inst", bus.id_inst, 32'h33); check("f2_pc", bus.id_pc, 32'h8);
    check("f2_valid", {31'b0, bus.id_valid}, 32'h1);

    // Redirect while rom_addr = 0x8.
    do_reset();
    step(0, 0, 0, 0); step(0, 0, 0, 0); step(0, 0, 0, 0);
    check("pre_redir_addr", bus.rom_addr, 32'h8);
    step(0, 0, 1, 32'h40);
    check("redir_inst", bus.id_inst, NOP);
    check("redir_valid", {31'b0, bus.id_valid}, 32'h0);
    check("redir_addr", bus.rom_addr, 32'h40);
    step(0, 0, 0, 0);
    check("redir_idpc", bus.id_pc, 32'h40);
    check("redir_tgt_inst", bus.id_inst, rom[16]);

    // Three-cycle stall at rom_addr = 0xC.
    do_reset();
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0, 0);
      check("stall_addr", bus.rom_addr, 32'hC);
      check("stall_idpc", bus.id_pc, 32'h8);
    end
    step(0, 0, 0, 0);
    check("unstall_idpc0", bus.id_pc, 32'hC);
    step(0, 0, 0, 0);
    check("unstall_idpc1", bus.id_pc, 32'h10);

    // Two redirects during a stall: the later one wins.
    step(1, 0, 1, 32'h80);
    step(1, 0, 1, 32'h90);
    check("pend_hold_addr", bus.rom_addr, 32'h14);
    step(0, 0, 0, 0);
    check("pend_bubble", {31'b0, bus.id_valid}, 32'h0);
    check("pend_addr", bus.rom_addr, 32'h90);
    step(0, 0, 0, 0);
    check("pend_idpc", bus.id_pc, 32'h90);
    check("pend_next_addr", bus.rom_addr, 32'h94);

    // Flush during stall.
    step(1, 1, 0, 0);
    check("flush_valid", {31'b0, bus.id_valid}, 32'h0);
    check("flush_inst", bus.id_inst, NOP);
    check("flush_addr", bus.rom_addr, 32'h94);

    // PC wrap.
    step(0, 0, 1, 32'hFFFF_FFFC);
    check("wrap_pre", bus.rom_addr, 32'hFFFF_FFFC);
    step(0, 0, 0, 0);
    check("wrap_addr", bus.rom_addr, 32'h0);
    check("wrap_idpc", bus.id_pc, 32'hFFFF_FFFC);

    // Reset with a pending redirect discards it.
    step(1, 0, 1, 32'h200);
    do_reset();
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    check("rst_pend_idpc", bus.id_pc, 32'h0);
    check("rst_pend_addr", bus.rom_addr, 32'h4);
    step(0, 0, 0, 0);
    check("rst_pend_addr2", bus.rom_addr, 32'h8);

    // Randomized traffic against the model.
    for (int n = 0; n < 600; n++) begin
      bit s, f, rv;
      logic [31:0] rt;
      s  = ($urandom_range(0, 3) == 0);
      f  = ($urandom_range(0, 9) == 0);
      rv = ($urandom_range(0, 6) == 0);
      rt = $urandom;
      if ($urandom_range(0, 3) != 0) rt[1:0] = 2'b00;
      if ($urandom_range(0, 199) == 0) do_reset();
      else step(s, f, rv, rt);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
